// File: rtl/pmod_keypad_scanner.sv
// pmod_keypad_scanner
// Scans a 4x4 banked PMOD key matrix: one bank is driven at a time, its four
// return lines are sampled, every key is debounced over whole scans, and
// press/release events are queued in a small valid/ready FIFO.
//
// Ports
//   SystemClock    clock
//   Reset          synchronous, active-high reset
//   Enable         1 = scanning runs, 0 = park in IDLE
//   ColumnSelect   registered one-hot bank drive, 0000 outside DRIVE
//   RowSense       raw asynchronous return lines
//   ScanBank       bank currently driven
//   KeyState       debounced key map, bit = bank*4 + row
//   EventValid     event FIFO non-empty
//   EventReady     consumer accepts the head event
//   EventKey       key index of the head event
//   EventPressed   1 = press, 0 = release (head event)
//   Overflow       sticky, an event was dropped on a full FIFO
//   ClearOverflow  clears Overflow
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | not scanning, waiting for Enable
// DRIVE  | one bank driven for SCAN_DIVIDER cycles, rows sampled at the end
// COMMIT | one cycle, whole-scan sample folded into debounce counters
// EMIT   | sixteen cycles, one key per cycle, changed keys pushed as events

module pmod_keypad_scanner #(
    parameter int SCAN_DIVIDER   = 10000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        SystemClock,
    input  logic        Reset,
    input  logic        Enable,
    output logic [3:0]  ColumnSelect,
    input  logic [3:0]  RowSense,
    output logic [1:0]  ScanBank,
    output logic [15:0] KeyState,
    output logic        EventValid,
    input  logic        EventReady,
    output logic [3:0]  EventKey,
    output logic        EventPressed,
    output logic        Overflow,
    input  logic        ClearOverflow
);

    localparam int DW = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DWELL_LOAD = DW'(SCAN_DIVIDER - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_LIMIT  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, COMMIT, EMIT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    rs_meta, rs_sync;
    logic [1:0]    bank_q, bank_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [15:0]   sample_q;
    logic [15:0]   key_state_q;
    logic [15:0]   change_q;
    logic [CW-1:0] cnt_q [16];
    logic [3:0]    emit_idx_q;
    logic [3:0]    col_q;
    logic          dwell_tc;
    logic          sample_we;
    logic          abort;
    logic          push;

    logic [4:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full;
    logic          pop, push_ok;
    logic          overflow_q;

    // Dwell is a down-counter: loaded with SCAN_DIVIDER-1, terminal at zero.
    assign dwell_tc = (dwell_q == '0);

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        dwell_d   = dwell_q;
        sample_we = 1'b0;
        abort     = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (Enable) begin
                    state_d = DRIVE;
                    bank_d  = 2'd0;
                    dwell_d = DWELL_LOAD;
                end
            end
            DRIVE: begin
                if (!Enable) begin
                    state_d = IDLE;
                    bank_d  = 2'd0;
                    abort   = 1'b1;
                end else if (dwell_tc) begin
                    sample_we = 1'b1;
                    if (bank_q == 2'd3) begin
                        state_d = COMMIT;
                    end else begin
                        bank_d  = bank_q + 2'd1;
                        dwell_d = DWELL_LOAD;
                    end
                end else begin
                    dwell_d = dwell_q - DWELL_ONE;
                end
            end
            COMMIT: begin
                state_d = EMIT;
            end
            EMIT: begin
                push = change_q[emit_idx_q];
                if (emit_idx_q == 4'd15) begin
                    state_d = Enable ? DRIVE : IDLE;
                    bank_d  = 2'd0;
                    dwell_d = DWELL_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge SystemClock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge SystemClock) begin
        if (Reset) begin
            rs_meta     <= '0;
            rs_sync     <= '0;
            bank_q      <= '0;
            dwell_q     <= '0;
            col_q       <= '0;
            sample_q    <= '0;
            key_state_q <= '0;
            change_q    <= '0;
            emit_idx_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rs_meta <= RowSense;
            rs_sync <= rs_meta;
            bank_q  <= bank_d;
            dwell_q <= dwell_d;
            // Drive is registered from the next state so it lines up with DRIVE.
            col_q   <= (state_d == DRIVE) ? (4'b0001 << bank_d) : 4'b0000;

            if (abort) begin
                sample_q <= '0;
            end else if (sample_we) begin
                sample_q[{bank_q, 2'b00} +: 4] <= rs_sync;
            end

            if (state_q == COMMIT) begin
                emit_idx_q <= 4'd0;
                for (int i = 0; i < 16; i++) begin
                    if (sample_q[i] == key_state_q[i]) begin
                        cnt_q[i]    <= '0;
                        change_q[i] <= 1'b0;
                    end else if (cnt_q[i] + CNT_ONE == CNT_LIMIT) begin
                        cnt_q[i]       <= '0;
                        key_state_q[i] <= ~key_state_q[i];
                        change_q[i]    <= 1'b1;
                    end else begin
                        cnt_q[i]    <= cnt_q[i] + CNT_ONE;
                        change_q[i] <= 1'b0;
                    end
                end
            end else if (state_q == EMIT) begin
                emit_idx_q <= emit_idx_q + 4'd1;
            end
        end
    end

    // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && EventReady;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge SystemClock) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr_q[AW-1:0]] <= {emit_idx_q, key_state_q[emit_idx_q]};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end else if (ClearOverflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign ColumnSelect = col_q;
    assign ScanBank     = bank_q;
    assign KeyState     = key_state_q;
    assign EventValid   = !fifo_empty;
    assign EventKey     = fifo_mem[rd_ptr_q[AW-1:0]][4:1];
    assign EventPressed = fifo_mem[rd_ptr_q[AW-1:0]][0];
    assign Overflow     = overflow_q;

endmodule

// File: tb/tb_pmod_keypad_scanner.sv
module tb_pmod_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  column_select;
    logic [3:0]  row_sense;
    logic [1:0]  scan_bank;
    logic [15:0] key_state;
    logic        event_valid;
    logic        event_ready;
    logic [3:0]  event_key;
    logic        event_pressed;
    logic        overflow;
    logic        clear_overflow;

    logic [15:0] keys;
    int          cyc;
    int          tests_run = 0;
    int          tests_failed = 0;

    pmod_keypad_scanner #(
        .SCAN_DIVIDER   (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .SystemClock   (clk),
        .Reset         (reset),
        .Enable        (enable),
        .ColumnSelect  (column_select),
        .RowSense      (row_sense),
        .ScanBank      (scan_bank),
        .KeyState      (key_state),
        .EventValid    (event_valid),
        .EventReady    (event_ready),
        .EventKey      (event_key),
        .EventPressed  (event_pressed),
        .Overflow      (overflow),
        .ClearOverflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key shorts its bank drive onto its row line.
    always_comb begin
        row_sense = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            if (column_select[b]) row_sense = row_sense | keys[b*4 +: 4];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cyc is the position within the 33-cycle scan seen at this negedge:
    // 0..15 DRIVE, 16 COMMIT, 17..32 EMIT.
    task automatic tick();
        @(negedge clk);
        cyc = (cyc + 1) % 33;
    endtask

    task automatic run_scan();
        repeat (33) tick();
    endtask

    task automatic to_cyc(input int n);
        for (int k = 0; k < 33 && cyc != n; k++) tick();
    endtask

    task automatic check_head(input string tag, input logic [3:0] key, input logic pressed);
        check({tag, "_valid"}, {31'd0, event_valid}, 32'd1);
        check({tag, "_key"}, {28'd0, event_key}, {28'd0, key});
        check({tag, "_pressed"}, {31'd0, event_pressed}, {31'd0, pressed});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        logic [3:0] drain_keys [4];

        reset = 1'b1; enable = 1'b0; event_ready = 1'b0;
        clear_overflow = 1'b0; keys = 16'h0000; cyc = 32;
        repeat (3) @(negedge clk);
        check("rst_col", {28'd0, column_select}, 32'd0);
        check("rst_bank", {30'd0, scan_bank}, 32'd0);
        check("rst_keystate", {16'd0, key_state}, 32'd0);
        check("rst_valid", {31'd0, event_valid}, 32'd0);
        check("rst_key", {28'd0, event_key}, 32'd0);
        check("rst_pressed", {31'd0, event_pressed}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // 1: scan pattern over two periods
        reset = 1'b0; enable = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 33; c++) begin
                tick();
                exp_col = (c < 16) ? (4'b0001 << (c / 4)) : 4'b0000;
                check("t1_col", {28'd0, column_select}, {28'd0, exp_col});
                if (c < 16) check("t1_bank", {30'd0, scan_bank}, c / 4);
            end
        end

        // 2: key 9 press then release
        keys = 16'h0200;
        run_scan();
        check("t2_ks_scan1", {16'd0, key_state}, 32'h0000);
        check("t2_valid_scan1", {31'd0, event_valid}, 32'd0);
        run_scan();
        check("t2_ks_scan2", {16'd0, key_state}, 32'h0200);
        check_head("t2_press", 4'd9, 1'b1);
        event_ready = 1'b1; tick(); event_ready = 1'b0;
        check("t2_popped", {31'd0, event_valid}, 32'd0);
        to_cyc(32);
        keys = 16'h0000;
        run_scan();
        check("t2_ks_rel1", {16'd0, key_state}, 32'h0200);
        check("t2_valid_rel1", {31'd0, event_valid}, 32'd0);
        run_scan();
        check("t2_ks_rel2", {16'd0, key_state}, 32'h0000);
        check_head("t2_release", 4'd9, 1'b0);
        event_ready = 1'b1; tick(); event_ready = 1'b0;
        check("t2_popped2", {31'd0, event_valid}, 32'd0);
        to_cyc(32);

        // 3: single-scan glitch on key 5, twice: counter must restart each time
        for (int r = 0; r < 2; r++) begin
            keys = 16'h0020;
            run_scan();
            check("t3_ks_glitch", {16'd0, key_state}, 32'h0000);
            keys = 16'h0000;
            run_scan();
            check("t3_ks_after", {16'd0, key_state}, 32'h0000);
            check("t3_valid", {31'd0, event_valid}, 32'd0);
        end

        // 4: six keys, FIFO fills, overflow, clear, drain
        keys = 16'h9249;
        run_scan();
        run_scan();
        check("t4_ks", {16'd0, key_state}, 32'h9249);
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        check_head("t4_head", 4'd0, 1'b1);
        // key 15 is dropped on the same edge as this clear: the drop wins
        clear_overflow = 1'b1; tick();
        check("t4_ovf_drop_wins", {31'd0, overflow}, 32'd1);
        tick(); clear_overflow = 1'b0;
        check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        drain_keys[0] = 4'd0; drain_keys[1] = 4'd3; drain_keys[2] = 4'd6; drain_keys[3] = 4'd9;
        event_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head("t4_drain", drain_keys[k], 1'b1);
            tick();
        end
        event_ready = 1'b0;
        check("t4_empty", {31'd0, event_valid}, 32'd0);
        to_cyc(32);

        // 5: disable mid-scan at bank 2 dwell 1, then re-enable
        keys = 16'h0000;
        to_cyc(9);
        check("t5_bank2", {28'd0, column_select}, 32'h4);
        enable = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("t5_idle_col", {28'd0, column_select}, 32'd0);
        end
        check("t5_ks_kept", {16'd0, key_state}, 32'h9249);
        enable = 1'b1; cyc = 32;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_col = 4'b0001 << (k / 4);
            check("t5_restart_col", {28'd0, column_select}, {28'd0, exp_col});
            check("t5_restart_bank", {30'd0, scan_bank}, k / 4);
        end
        to_cyc(32);
        // aborted scan must not have counted: one disagreeing scan only
        check("t5_ks_one_scan", {16'd0, key_state}, 32'h9249);
        check("t5_valid", {31'd0, event_valid}, 32'd0);

        // 6: push onto a full FIFO while popping
        to_cyc(29);
        check("t6_full_head", {28'd0, event_key}, 32'd0);
        event_ready = 1'b1; tick(); event_ready = 1'b0;
        check("t6_ovf_clear", {31'd0, overflow}, 32'd0);
        check_head("t6_head", 4'd3, 1'b0);
        to_cyc(0);
        check("t6_ovf_key15", {31'd0, overflow}, 32'd1);
        check("t6_ks", {16'd0, key_state}, 32'h0000);
        drain_keys[0] = 4'd3; drain_keys[1] = 4'd6; drain_keys[2] = 4'd9; drain_keys[3] = 4'd12;
        event_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head("t6_drain", drain_keys[k], 1'b0);
            tick();
        end
        event_ready = 1'b0;
        check("t6_empty", {31'd0, event_valid}, 32'd0);
        to_cyc(32);

        // reset in the middle of EMIT
        keys = 16'h0003;
        run_scan();
        to_cyc(20);
        check("t6_pre_ks", {16'd0, key_state}, 32'h0003);
        check_head("t6_pre_head", 4'd0, 1'b1);
        reset = 1'b1; tick();
        check("t6_rst_col", {28'd0, column_select}, 32'd0);
        check("t6_rst_bank", {30'd0, scan_bank}, 32'd0);
        check("t6_rst_ks", {16'd0, key_state}, 32'd0);
        check("t6_rst_valid", {31'd0, event_valid}, 32'd0);
        check("t6_rst_key", {28'd0, event_key}, 32'd0);
        check("t6_rst_pressed", {31'd0, event_pressed}, 32'd0);
        check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0; tick();
        check("t6_restart_col", {28'd0, column_select}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
